// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the core data-bus controller.
// Holds the controller state enum, the d_size encodings, the default RAM
// window width and the alignment helper.
package mem_bus_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_IO_BUSY, ST_IO_DONE} state_t;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int RAM_ADDR_BITS_DEF = 12;
    // size 11 falls into the word case through the >= compare
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF) ? off[0] : (size >= SZ_WORD) ? |off : 1'b0;
    endfunction
endpackage

// File: rtl/mem_load_fmt.sv
// mem_load_fmt: picks the byte/half/word lane of a 32-bit read word and extends it.
// Ports: i_data read word, i_off byte offset, i_size access size,
//        i_unsigned zero-extend when set, o_data right-aligned result.
module mem_load_fmt
    import mem_bus_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_byte = i_data[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
    assign o_data = (i_size == SZ_BYTE) ? {{24{w_byte[7] & ~i_unsigned}}, w_byte} :
                    (i_size == SZ_HALF) ? {{16{w_half[15] & ~i_unsigned}}, w_half} : i_data;
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: routes core loads/stores to a zero-wait RAM or a handshaked IO bus.
// Ports: clk/reset; d_* core request side (d_stall holds the core, d_err flags
//        misalignment or IO timeout); mem0_* combinational RAM port;
//        io_* IO request with single-cycle io_ack completion.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
    parameter int IO_W          = 16,
    parameter int TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d_req,
    input  logic                     d_rw,
    input  logic [31:0]              daddr,
    input  logic [31:0]              ddata_w,
    input  logic [1:0]               d_size,
    input  logic                     d_unsigned,
    output logic [31:0]              ddata_r,
    output logic                     d_stall,
    output logic                     d_err,
    output logic                     mem0_ena,
    output logic                     mem0_rw,
    output logic [3:0]               mem0_be,
    output logic [RAM_ADDR_BITS-1:0] mem0_addr,
    output logic [31:0]              mem0_dw,
    input  logic [31:0]              mem0_dr,
    output logic                     io_req,
    output logic                     io_rw,
    output logic [31:0]              io_addr,
    output logic [IO_W-1:0]          io_dout,
    input  logic [IO_W-1:0]          io_din,
    input  logic                     io_ack
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t          r_state, w_state_nxt;
    logic [31:0]     r_addr;
    logic            r_rw;
    logic [IO_W-1:0] r_wdata;
    logic [IO_W-1:0] r_rdata;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            w_ram, w_mis, w_start, w_timeout;
    logic [3:0]      w_be;
    logic [31:0]     w_ram_ld, w_io_ld;
    assign w_ram     = (daddr >> RAM_ADDR_BITS) == 32'd0;
    assign w_mis     = misaligned(d_size, daddr[1:0]);
    assign w_be      = d_size[1] ? 4'b1111 : d_size[0] ? (daddr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << daddr[1:0];
    // last IO_BUSY cycle: counter is about to reach TIMEOUT
    assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
    assign mem0_addr = daddr[RAM_ADDR_BITS-1:0];
    assign mem0_dw   = d_size[1] ? ddata_w : d_size[0] ? {2{ddata_w[15:0]}} : {4{ddata_w[7:0]}};
    assign io_rw     = r_rw;
    assign io_addr   = r_addr;
    assign io_dout   = r_wdata;
    mem_load_fmt u_ram_fmt (
        .i_data     (mem0_dr),
        .i_off      (daddr[1:0]),
        .i_size     (d_size),
        .i_unsigned (d_unsigned),
        .o_data     (w_ram_ld)
    );
    // IO data always arrives in lane 0
    mem_load_fmt u_io_fmt (
        .i_data     (32'(r_rdata)),
        .i_off      (2'b00),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_io_ld)
    );
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        d_stall     = 1'b0;
        d_err       = 1'b0;
        ddata_r     = 32'd0;
        mem0_ena    = 1'b0;
        mem0_rw     = d_rw;
        mem0_be     = 4'b0000;
        io_req      = 1'b0;
        case (r_state)
            ST_IDLE: if (d_req) begin
                if (w_mis) begin
                    d_err = 1'b1;
                end else if (w_ram) begin
                    mem0_ena = 1'b1;
                    mem0_be  = d_rw ? w_be : 4'b0000;
                    ddata_r  = d_rw ? 32'd0 : w_ram_ld;
                end else begin
                    d_stall     = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = ST_IO_BUSY;
                end
            end
            ST_IO_BUSY: begin
                io_req  = 1'b1;
                d_stall = 1'b1;
                if (io_ack || w_timeout) w_state_nxt = ST_IO_DONE;
            end
            ST_IO_DONE: begin
                ddata_r     = w_io_ld;
                d_err       = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_addr  <= daddr;
                r_rw    <= d_rw;
                r_wdata <= ddata_w[IO_W-1:0];
                r_size  <= d_size;
                r_uns   <= d_unsigned;
                r_cnt   <= '0;
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
            // ack wins over timeout when both land in the same cycle
            if (r_state == ST_IO_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
                if (io_ack) r_rdata <= io_din;
                else if (w_timeout) r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed self-checking bench for mem_bus_ctrl with a behavioural model.
module tb_mem_bus_ctrl;
    localparam int RAB = 12;
    localparam int IOW = 16;
    localparam int TO  = 15;
    logic           clk = 1'b0, reset = 1'b1;
    logic           d_req = 1'b0, d_rw = 1'b0, d_unsigned = 1'b0;
    logic [31:0]    daddr = '0, ddata_w = '0, mem0_dr = '0;
    logic [1:0]     d_size = '0;
    logic [31:0]    ddata_r, mem0_dw, io_addr;
    logic           d_stall, d_err, mem0_ena, mem0_rw, io_req, io_rw;
    logic [3:0]     mem0_be;
    logic [RAB-1:0] mem0_addr;
    logic [IOW-1:0] io_dout, io_din = '0;
    logic           io_ack = 1'b0;
    int             n_pass = 0, n_total = 0;
    bit             started = 1'b0;
    always #5 clk = ~clk;
    mem_bus_ctrl #(.RAM_ADDR_BITS(RAB), .IO_W(IOW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .d_req(d_req), .d_rw(d_rw), .daddr(daddr),
        .ddata_w(ddata_w), .d_size(d_size), .d_unsigned(d_unsigned), .ddata_r(ddata_r),
        .d_stall(d_stall), .d_err(d_err), .mem0_ena(mem0_ena), .mem0_rw(mem0_rw),
        .mem0_be(mem0_be), .mem0_addr(mem0_addr), .mem0_dw(mem0_dw), .mem0_dr(mem0_dr),
        .io_req(io_req), .io_rw(io_rw), .io_addr(io_addr), .io_dout(io_dout),
        .io_din(io_din), .io_ack(io_ack)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    function automatic logic [31:0] m_load(input logic [31:0] d, input int off, input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (off * 8)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (d >> ((off / 2) * 16)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else v = d;
        return v;
    endfunction
    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz >= 2'd2) return 4'hF;
        if (sz == 2'd1) return (a % 4 >= 2) ? 4'hC : 4'h3;
        return 4'(1 << (a % 4));
    endfunction
    function automatic bit m_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0);
    endfunction
    function automatic logic [31:0] m_dw(input logic [31:0] w, input logic [1:0] sz);
        if (sz >= 2'd2) return w;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return (w & 32'hFF) * 32'h0101_0101;
    endfunction
    int          m_phase = 0, m_wait = 0;
    logic [31:0] m_addr;
    bit          m_rw, m_uns, m_err;
    logic [15:0] m_wd, m_data;
    logic [1:0]  m_sz;
    always @(negedge clk) if (started) begin
        if (m_phase == 0) begin
            if (!d_req) begin
                chk("idle_stall", d_stall, 0); chk("idle_err", d_err, 0);
                chk("idle_rdata", ddata_r, 0); chk("idle_ena", mem0_ena, 0); chk("idle_ioreq", io_req, 0);
            end else if (m_mis(daddr, d_size)) begin
                chk("mis_err", d_err, 1); chk("mis_rdata", ddata_r, 0); chk("mis_ena", mem0_ena, 0);
                chk("mis_stall", d_stall, 0); chk("mis_ioreq", io_req, 0); chk("mis_be", mem0_be, 0);
            end else if (daddr < 32'h1000) begin
                chk("ram_ena", mem0_ena, 1); chk("ram_rw", mem0_rw, d_rw);
                chk("ram_be", mem0_be, d_rw ? m_be(daddr, d_size) : 4'h0);
                chk("ram_addr", mem0_addr, daddr % 4096); chk("ram_stall", d_stall, 0);
                chk("ram_err", d_err, 0); chk("ram_ioreq", io_req, 0);
                if (d_rw) chk("ram_dw", mem0_dw, m_dw(ddata_w, d_size));
                else chk("ram_rdata", ddata_r, m_load(mem0_dr, int'(daddr % 4), d_size, d_unsigned));
            end else begin
                chk("io_start_stall", d_stall, 1); chk("io_start_ena", mem0_ena, 0);
                chk("io_start_ioreq", io_req, 0); chk("io_start_err", d_err, 0);
            end
        end else if (m_phase == 1) begin
            chk("busy_ioreq", io_req, 1); chk("busy_stall", d_stall, 1); chk("busy_iorw", io_rw, m_rw);
            chk("busy_ioaddr", io_addr, m_addr); chk("busy_iodout", io_dout, m_wd);
            chk("busy_ena", mem0_ena, 0); chk("busy_err", d_err, 0);
        end else begin
            chk("done_stall", d_stall, 0); chk("done_ioreq", io_req, 0);
            chk("done_ena", mem0_ena, 0); chk("done_err", d_err, m_err);
            if (!m_err) chk("done_rdata", ddata_r, m_load(32'(m_data), 0, m_sz, m_uns));
        end
        if (reset) m_phase = 0;
        else if (m_phase == 0) begin
            if (d_req && !m_mis(daddr, d_size) && daddr >= 32'h1000) begin
                m_addr = daddr; m_rw = d_rw; m_wd = ddata_w[15:0]; m_sz = d_size; m_uns = d_unsigned;
                m_wait = 0; m_err = 0; m_data = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_wait++;
            if (io_ack) begin m_data = io_din; m_phase = 2; end
            else if (m_wait == TO) begin m_err = 1; m_phase = 2; end
        end else m_phase = 0;
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_req(input bit rw, input logic [31:0] a, input logic [31:0] w, input logic [1:0] sz, input bit u);
        d_req = 1'b1; d_rw = rw; daddr = a; ddata_w = w; d_size = sz; d_unsigned = u;
    endtask
    task automatic io_txn(input bit rw, input logic [31:0] a, input logic [31:0] w, input logic [1:0] sz,
                          input bit u, input int ack_at, input logic [15:0] din,
                          output int stalls, output logic [31:0] rd, output logic err);
        step();
        set_req(rw, a, w, sz, u);
        io_ack = 1'b0; io_din = din; stalls = 0; rd = 'x; err = 1'bx;
        for (int c = 0; c < 40; c++) begin
            #3;
            if (!d_stall) begin rd = ddata_r; err = d_err; break; end
            stalls++;
            step();
            io_ack = (c + 1 == ack_at);
        end
        step();
        d_req = 1'b0; io_ack = 1'b0;
    endtask
    typedef struct packed {
        logic        rw;
        logic [31:0] a;
        logic [31:0] w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] dr;
    } vec_t;
    vec_t vecs [0:10];
    int          st;
    logic [31:0] rd;
    logic        er;
    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0002, 32'h0000_CAFE, 2'b01, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0001, 32'h0,         2'b00, 1'b0, 32'h0000_8000};
        vecs[4]  = '{1'b0, 32'h0000_0001, 32'h0,         2'b00, 1'b1, 32'h0000_8000};
        vecs[5]  = '{1'b0, 32'h0000_0008, 32'h0,         2'b11, 1'b0, 32'h8765_4321};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         2'b01, 1'b0, 32'h1234_F00D};
        vecs[7]  = '{1'b1, 32'h0000_0005, 32'h0000_1111, 2'b01, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_000A, 32'h0,         2'b11, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_1001, 32'h0,         2'b01, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0FFF, 32'h0,         2'b00, 1'b0, 32'h7F00_0000};
        repeat (2) @(posedge clk);
        #1 started = 1'b1;
        #3;
        chk("rst_ioreq", io_req, 0); chk("rst_stall", d_stall, 0);
        chk("rst_rdata", ddata_r, 0); chk("rst_ena", mem0_ena, 0);
        step(); reset = 1'b0;
        step(); set_req(1'b1, 32'h3, 32'hA5, 2'b00, 1'b0);
        #3 chk("sb_be", mem0_be, 4'b1000); chk("sb_dw", mem0_dw, 32'hA5A5_A5A5); chk("sb_stall", d_stall, 0);
        step(); set_req(1'b0, 32'h2, 32'h0, 2'b01, 1'b0); mem0_dr = 32'h8001_0000;
        #3 chk("lh_signed", ddata_r, 32'hFFFF_8001);
        step(); d_unsigned = 1'b1;
        #3 chk("lhu", ddata_r, 32'h0000_8001);
        step(); set_req(1'b0, 32'h6, 32'h0, 2'b10, 1'b0);
        #3 chk("lw_mis_err", d_err, 1); chk("lw_mis_ena", mem0_ena, 0); chk("lw_mis_stall", d_stall, 0);
        foreach (vecs[i]) begin
            step();
            set_req(vecs[i].rw, vecs[i].a, vecs[i].w, vecs[i].sz, vecs[i].u);
            mem0_dr = vecs[i].dr;
        end
        step(); d_req = 1'b0; io_ack = 1'b1;
        step(); io_ack = 1'b0;
        io_txn(1'b0, 32'h0000_1000, 32'h0, 2'b01, 1'b0, 3, 16'hBEEF, st, rd, er);
        chk("io_lh_stalls", st, 4); chk("io_lh_rdata", rd, 32'hFFFF_BEEF); chk("io_lh_err", er, 0);
        io_txn(1'b1, 32'h2000_0004, 32'h1234_5678, 2'b10, 1'b0, 1, 16'h0, st, rd, er);
        chk("io_min_stalls", st, 2); chk("io_min_err", er, 0);
        io_txn(1'b0, 32'h0000_1000, 32'h0, 2'b10, 1'b0, 0, 16'h1111, st, rd, er);
        chk("io_to_stalls", st, TO + 1); chk("io_to_err", er, 1);
        io_txn(1'b0, 32'h0000_1002, 32'h0, 2'b00, 1'b1, TO, 16'h77C3, st, rd, er);
        chk("io_late_stalls", st, TO + 1); chk("io_late_err", er, 0); chk("io_late_rdata", rd, 32'h0000_00C3);
        io_txn(1'b0, 32'h0000_1003, 32'h0, 2'b00, 1'b0, 2, 16'h0080, st, rd, er);
        chk("io_lb_stalls", st, 3); chk("io_lb_rdata", rd, 32'hFFFF_FF80);
        step(); set_req(1'b0, 32'h0000_3000, 32'h0, 2'b10, 1'b0);
        step();
        step(); reset = 1'b1; d_req = 1'b0;
        step();
        #3 chk("rst_busy_ioreq", io_req, 0); chk("rst_busy_stall", d_stall, 0);
        step(); reset = 1'b0; io_ack = 1'b1;
        step(); io_ack = 1'b0;
        #3 chk("post_rst_ioreq", io_req, 0); chk("post_rst_stall", d_stall, 0);
        chk("post_rst_err", d_err, 0); chk("post_rst_rdata", ddata_r, 0);
        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameters SHALL be: RAM_ADDR_BITS, default 12, RAM window is addresses [0, 2**RAM_ADDR_BITS); IO_W, default 16, IO data width (16 or 32); TIMEOUT, default 15, maximum IO wait cycles before error.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- d_req  in  1  core access valid.
- d_rw  in  1  1=write.
- daddr  in  32  byte address.
- ddata_w  in  32  store data, right-aligned.
- d_size  in  2  00 byte, 01 half, 10 word.
- d_unsigned  in  1  zero-extend loads.
- ddata_r  out  32  formatted load data.
- d_stall  out  1  core must hold all d_* inputs.
- d_err  out  1  misaligned access or IO timeout.
- mem0_ena  out  1  RAM enable.
- mem0_rw  out  1  RAM write.
- mem0_be  out  4  RAM byte enables.
- mem0_addr  out  RAM_ADDR_BITS  RAM byte address.
- mem0_dw  out  32  lane-replicated store data.
- mem0_dr  in  32  RAM read data.
- io_req  out  1  IO request.
- io_rw  out  1  IO write.
- io_addr  out  32  IO address.
- io_dout  out  IO_W  IO write data.
- io_din  in  IO_W  IO read data.
- io_ack  in  1  IO completion, single-cycle pulse.

Function
REQ-004 Region decode SHALL be RAM when daddr < 2**RAM_ADDR_BITS, IO otherwise.
REQ-005 Misaligned access SHALL be a half with daddr[0]=1, or a word with daddr[1:0]!=0; d_size=11 SHALL be treated as a word.
REQ-006 A misaligned request SHALL assert d_err in the same cycle, with ddata_r=0, no enables, no stall, and no state change.
REQ-007 The RAM path SHALL be combinational with zero stall.
- mem0_ena=d_req; mem0_rw=d_rw.
- mem0_be: byte gives 1<<daddr[1:0]; half gives 0011 or 1100 by daddr[1]; word gives 1111.
- mem0_dw replicates the byte or half across lanes.
- mem0_be SHALL be 0 on reads.
REQ-008 RAM loads SHALL extract the lane selected by daddr[1:0]; they are sign-extended unless d_unsigned=1.
REQ-009 The FSM SHALL have states IDLE, IO_BUSY and IO_DONE.
REQ-010 In IDLE, an aligned IO request SHALL:
- assert d_stall combinationally;
- latch daddr, d_rw, ddata_w[IO_W-1:0], d_size and d_unsigned;
- move to IO_BUSY.
REQ-011 In IO_BUSY:
- io_req=1, with io_rw, io_addr and io_dout driven from the latched registers;
- d_stall=1;
- the wait counter increments each cycle.
REQ-012 On io_ack in IO_BUSY, the FSM SHALL capture io_din and move to IO_DONE.
REQ-013 If the counter reaches TIMEOUT without io_ack, the FSM SHALL move to IO_DONE with an error flag set.
REQ-014 In IO_DONE:
- d_stall=0 and io_req=0;
- ddata_r = captured data, formatted by the latched size and sign, from lane 0 of io_din zero-extended to 32 bits;
- d_err = the error flag;
- next state is IDLE unconditionally.
REQ-015 Minimum IO stall SHALL be 2 cycles (ack in the first IO_BUSY cycle); maximum stall SHALL be TIMEOUT+1 cycles.
REQ-016 In IO_BUSY, changes on d_* inputs SHALL be ignored, and io_ack arriving in IDLE or IO_DONE SHALL be ignored.
REQ-017 An io_ack arriving in the same cycle the counter hits TIMEOUT SHALL count as success, with no error.
REQ-018 When d_req=0 in IDLE, all enables, d_stall and d_err SHALL be 0, and ddata_r SHALL be 0.

Reset
REQ-019 Reset SHALL force:
- state IDLE;
- counter, error flag, captured data and latched registers to 0;
- io_req=0.
REQ-020 Reset asserted during IO_BUSY SHALL drop io_req at the next clock edge; a later io_ack SHALL be ignored.

Structure
REQ-021 Package mem_bus_pkg SHALL hold the state enum, the d_size encodings and the default RAM_ADDR_BITS constant.
REQ-022 Sub-module mem_load_fmt SHALL perform lane extraction and sign or zero extension, and SHALL be instantiated for both the RAM and IO paths.

Verification
REQ-023 RAM store: SB to 0x0000_0003 with ddata_w=0x0000_00A5 -> mem0_be=1000, mem0_dw=0xA5A5A5A5, d_stall=0.
REQ-024 RAM load: LH signed at 0x2 with mem0_dr=0x8001_0000 -> ddata_r=0xFFFF_8001; LHU -> 0x0000_8001.
REQ-025 Misaligned: LW at 0x0000_0006 -> d_err=1, mem0_ena=0, d_stall=0.
REQ-026 IO read: address 0x0000_1000, io_ack on the 3rd IO_BUSY cycle, io_din=0xBEEF, LH -> 4 stall cycles, then ddata_r=0xFFFF_BEEF.
REQ-027 IO timeout and reset:
- no io_ack -> d_err=1 after TIMEOUT+1 stall cycles;
- reset mid-IO_BUSY -> io_req=0 next cycle, state IDLE.
